// File: rtl/octal_ascii_serializer_pkg.sv
// Shared types and constants for the octal ASCII serializer.
package octal_ser_pkg;

  typedef enum logic [1:0] {IDLE, SKIP, EMIT, TERM} state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;

  // Number of 3-bit octal digit slots needed to hold a w-bit value.
  function automatic int ndig(input int w);
    return (w + 2) / 3;
  endfunction

endpackage

// File: rtl/octal_ascii_serializer_if.sv
// Input word handshake and output character stream of the octal serializer.
interface octal_ascii_serializer_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_char;
  logic              out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_char, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_char, out_last
  );
endinterface

// File: rtl/octal_ascii_serializer.sv
// Prints a binary word as base-8 ASCII text, MSD first, with optional
// leading-zero suppression and a terminator character per word.
module octal_ascii_serializer
  import octal_ser_pkg::*;
#(
  parameter int         DATA_W      = 16,
  parameter logic [7:0] TERM_CHAR   = 8'h0A,
  parameter bit         LZ_SUPPRESS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  octal_ascii_serializer_if.slave  bus,
  output logic                     busy
);

  localparam int NDIG   = ndig(DATA_W);
  localparam int SREG_W = NDIG * 3;
  localparam int CNT_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t            state;
  logic [SREG_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;
  logic              out_valid_q;
  logic              out_last_q;
  logic [2:0]        digit;
  logic              skip_zero;

  assign digit     = sreg[SREG_W-1 -: 3];
  // The final digit is never skipped, so an all-zero word still prints '0'.
  assign skip_zero = LZ_SUPPRESS && (digit == 3'd0) && (cnt != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sreg        <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sreg  <= SREG_W'(bus.in_data);
            cnt   <= CNT_W'(NDIG - 1);
            state <= SKIP;
          end
        end
        SKIP: begin
          if (skip_zero) begin
            sreg <= {sreg[SREG_W-4:0], 3'b000};
            cnt  <= cnt - 1'b1;
          end else begin
            out_valid_q <= 1'b1;
            state       <= EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (cnt == '0) begin
              out_last_q <= 1'b1;
              state      <= TERM;
            end else begin
              sreg <= {sreg[SREG_W-4:0], 3'b000};
              cnt  <= cnt - 1'b1;
            end
          end
        end
        TERM: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: out_char gets a default before the case so no path infers a latch.
  always_comb begin
    bus.out_char = 8'h00;
    unique case (state)
      EMIT:    bus.out_char = ASCII_ZERO + {5'b00000, digit};
      TERM:    bus.out_char = TERM_CHAR;
      default: bus.out_char = 8'h00;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_octal_ascii_serializer.sv
// Directed and randomized checks of the octal serializer against a digit model.
module tb_octal_ascii_serializer;

  localparam int DATA_W = 16;
  localparam int NDIG   = 6;

  logic clk;
  logic rst_n;
  logic busy0, busy1;
  int   checks = 0;
  int   fails  = 0;

  octal_ascii_serializer_if #(.DATA_W(DATA_W)) bus0 ();
  octal_ascii_serializer_if #(.DATA_W(DATA_W)) bus1 ();

  octal_ascii_serializer #(.DATA_W(DATA_W), .TERM_CHAR(8'h0A), .LZ_SUPPRESS(1'b1)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0.slave),
    .busy (busy0)
  );

  octal_ascii_serializer #(.DATA_W(DATA_W), .TERM_CHAR(8'h0A), .LZ_SUPPRESS(1'b0)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1.slave),
    .busy (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ov(input bit sel);
    return sel ? bus1.out_valid : bus0.out_valid;
  endfunction
  function automatic logic get_ir(input bit sel);
    return sel ? bus1.in_ready : bus0.in_ready;
  endfunction
  function automatic logic get_last(input bit sel);
    return sel ? bus1.out_last : bus0.out_last;
  endfunction
  function automatic logic [7:0] get_char(input bit sel);
    return sel ? bus1.out_char : bus0.out_char;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy1 : busy0;
  endfunction

  task automatic set_in(input bit sel, input logic v, input logic [DATA_W-1:0] d);
    if (sel) begin bus1.in_valid = v; bus1.in_data = d; end
    else     begin bus0.in_valid = v; bus0.in_data = d; end
  endtask
  task automatic set_rdy(input bit sel, input logic r);
    if (sel) bus1.out_ready = r;
    else     bus0.out_ready = r;
  endtask

  // Reference: base-8 digits by division, optional leading-zero strip, terminator.
  task automatic model(input int value, input bit lz, output logic [7:0] q[$], output int z);
    int d[NDIG];
    int v;
    v = value;
    for (int i = NDIG - 1; i >= 0; i--) begin
      d[i] = v % 8;
      v    = v / 8;
    end
    z = 0;
    if (lz) while (z < NDIG - 1 && d[z] == 0) z++;
    q = {};
    for (int i = z; i < NDIG; i++) q.push_back(8'(8'h30 + d[i]));
    q.push_back(8'h0A);
  endtask

  // Accept one word, then consume its characters. stop_after>0 leaves the word
  // in flight after that many characters; inject pulses in_valid=621 mid-word.
  task automatic run_word(input bit sel, input int value, input int stall,
                          input int stop_after, input bit inject);
    logic [7:0] exp_q[$];
    int z;
    int k;
    model(value, !sel, exp_q, z);

    k = 0;
    while (!get_ir(sel) && k < 40) begin
      @(posedge clk); #1; k++;
    end
    check("accept_ready", get_ir(sel), 1'b1);
    set_in(sel, 1'b1, DATA_W'(value));
    @(posedge clk); #1;
    set_in(sel, 1'b0, '0);
    set_rdy(sel, stall == 0);

    k = 0;
    while (!get_ov(sel) && k < 40) begin
      @(posedge clk); #1; k++;
    end
    check("first_valid_latency", k, 1 + z);

    for (int i = 0; i < exp_q.size(); i++) begin
      if (stop_after > 0 && i == stop_after) return;
      for (int s = 0; s < stall; s++) begin
        check("stall_valid", get_ov(sel), 1'b1);
        check("stall_char", get_char(sel), exp_q[i]);
        check("stall_in_ready", get_ir(sel), 1'b0);
        @(posedge clk); #1;
      end
      set_rdy(sel, 1'b1);
      if (inject && i == 1) set_in(sel, 1'b1, 16'd621);
      check("char_valid", get_ov(sel), 1'b1);
      check("char_value", get_char(sel), exp_q[i]);
      check("char_last", get_last(sel), i == exp_q.size() - 1);
      check("busy_in_ready", get_ir(sel), 1'b0);
      @(posedge clk); #1;
      if (inject && i == 1) set_in(sel, 1'b0, '0);
      set_rdy(sel, stall == 0);
    end
    check("post_valid", get_ov(sel), 1'b0);
    check("post_in_ready", get_ir(sel), 1'b1);
    check("post_busy", get_busy(sel), 1'b0);
  endtask

  initial begin
    int v;
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, '0);
    set_in(1'b1, 1'b0, '0);
    set_rdy(1'b0, 1'b0);
    set_rdy(1'b1, 1'b0);
    #12;
    check("rst_out_valid", bus0.out_valid, 1'b0);
    check("rst_out_last", bus0.out_last, 1'b0);
    check("rst_out_char", bus0.out_char, 8'h00);
    check("rst_busy", busy0, 1'b0);
    #10;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", bus0.in_ready, 1'b1);
    @(posedge clk); #1;

    run_word(1'b0, 127,   0, 0, 1'b0);
    run_word(1'b0, 0,     0, 0, 1'b0);
    run_word(1'b0, 65535, 0, 0, 1'b0);
    run_word(1'b0, 261,   5, 0, 1'b0);
    run_word(1'b0, 489,   0, 0, 1'b1);
    run_word(1'b0, 621,   0, 0, 1'b0);

    // Reset mid-word: out_valid must fall without a clock edge.
    run_word(1'b0, 1473, 0, 2, 1'b0);
    check("pre_reset_valid", bus0.out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", bus0.out_valid, 1'b0);
    check("async_reset_busy", busy0, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("release_in_ready", bus0.in_ready, 1'b1);
    check("release_out_char", bus0.out_char, 8'h00);
    @(posedge clk); #1;
    run_word(1'b0, 8, 0, 0, 1'b0);

    for (int n = 0; n < 16; n++) begin
      v = int'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      run_word(1'b0, v, int'($urandom_range(0, 2)), 0, 1'b0);
    end

    set_rdy(1'b0, 1'b0);
    run_word(1'b1, 8, 0, 0, 1'b0);
    run_word(1'b1, 0, 1, 0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      v = int'($urandom_range(0, 65535) >> $urandom_range(0, 15));
      run_word(1'b1, v, int'($urandom_range(0, 2)), 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/octal_ascii_serializer.md
Name: octal_ascii_serializer

Overview:
- Downstream consumer of the 16-bit decimal-to-octal conversion stage.
- Takes a binary value over a valid/ready input handshake and emits its base-8 representation as ASCII characters, most significant digit first, over a valid/ready output stream.
- Leading zeros are optionally suppressed, and a terminator character ends each word.
- Feeds the debug UART/console path, so converted values print as octal text.

Parameters:
- DATA_W, 16, width of the input value.
- NDIG, (DATA_W+2)/3 = 6, number of octal digit slots. Derived; do not override.
- TERM_CHAR, 8'h0A, character emitted after the last digit.
- LZ_SUPPRESS, 1, 1 = drop leading zero digits; 0 = always emit NDIG digits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word
- in_data  input  DATA_W  binary value to print
- out_valid  output  1  out_char is valid
- out_ready  input  1  sink accepts out_char
- out_char  output  8  ASCII character ('0'..'7' or TERM_CHAR)
- out_last  output  1  high with the terminator character
- busy  output  1  high whenever state != IDLE

Interface decision: one clock, clk. Reset is rst_n, asynchronous and active-low.

Behaviour:
- Reset (asserted at any time, including mid-word):
  - State goes to IDLE immediately; the word in flight is discarded.
  - Shift register and digit counter clear.
  - out_valid=0, out_last=0, out_char=8'h00, busy=0, in_ready=1 once rst_n deasserts.
- Internal datapath:
  - sreg is NDIG*3 bits (18), holding the zero-extended in_data.
  - The current digit is sreg[top 3 bits].
  - cnt counts the digits remaining, NDIG-1 down to 0.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: load sreg, set cnt=NDIG-1, go to SKIP.
  - in_valid while not IDLE is ignored; in_ready=0 in every other state.
- SKIP (one cycle per suppressed digit, no output):
  - If LZ_SUPPRESS && digit==0 && cnt!=0: shift sreg left by 3, decrement cnt, stay in SKIP.
  - Otherwise go to EMIT.
  - An all-zero value therefore prints a single '0'.
  - With LZ_SUPPRESS=0, SKIP always exits after one cycle.
- EMIT:
  - out_valid=1, out_char = 8'h30 + digit, out_last=0.
  - On out_ready: if cnt==0 go to TERM; else shift sreg, decrement cnt, stay in EMIT.
  - Without out_ready, out_char and out_valid hold stable. Dropping out_valid without a handshake is a bug.
- TERM:
  - out_valid=1, out_char=TERM_CHAR, out_last=1.
  - On out_ready go to IDLE; in_ready rises the next cycle.
- Latency:
  - The first out_valid is asserted 1+z cycles after the acceptance edge, where z is the number of suppressed zeros.
  - Example: 127 = 0o000177, z=3, so out_valid is first seen 4 cycles later.
  - With out_ready tied high, each character takes 1 cycle.
  - A word completes in 1+z+d+1 cycles, where d is the number of emitted digits.
- Outputs: out_char is decoded from registered state only, with no combinational path from out_ready to out_valid/out_char. out_valid and out_last are registered.
- Throughput: one word in flight, with no overlap between output of word N and acceptance of word N+1.

Decomposition:
- Package octal_ser_pkg holds:
  - state enum {IDLE, SKIP, EMIT, TERM}
  - ASCII_ZERO = 8'h30
  - function ndig(w) = (w+2)/3
- No sub-module. The digit-to-ASCII step is a single add; keep it inline.

Test Plan:
- Accept 127 with out_ready=1 -> stream '1','7','7',8'h0A; out_last only on 8'h0A; first out_valid 4 cycles after acceptance.
- Accept 0 -> '0',8'h0A. Accept 65535 -> '1','7','7','7','7','7',8'h0A with no SKIP cycles.
- Accept 261, out_ready low for 5 cycles on each character -> out_char holds 8'h34, 8'h30, 8'h35 stable while stalled; sequence "405\n"; in_ready=0 throughout.
- Accept 489, pulse in_valid with 621 mid-stream -> 621 ignored; output "751\n"; in_ready=1 the cycle after the terminator handshake; then 621 -> "1155\n".
- Accept 1473, assert rst_n=0 asynchronously after the second character -> out_valid drops without waiting for a clock edge; after release in_ready=1. Accept 8 -> "10\n" with no residue from 1473.
- LZ_SUPPRESS=0, accept 8 -> "000010\n" (six digits plus terminator).
